// File: rtl/subpel_block_drain.sv
// Parallel-to-serial drain: one packed 40-word block in, 64-bit words out, first-in word first.
// Optional DRAIN_PRELOAD_EN: accept the next block on the final word handshake (zero-bubble streaming).
module subpel_block_drain #(
    parameter int WORD_W    = 64,
    parameter int NUM_WORDS = 40,
    parameter int CNT_W     = 6,
    parameter int BCNT_W    = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        blk_valid,
    output logic                        blk_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] blk_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_data,
    output logic [CNT_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        busy,
    output logic [BCNT_W-1:0]           blk_count
);

    localparam int BUS_W = WORD_W * NUM_WORDS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [BUS_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [BCNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend only on registered state; out_ready never reaches out_valid.
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign out_data  = buf_q[BUS_W-1 -: WORD_W];
    assign out_idx   = idx_q;
    assign blk_count = cnt_q;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        blk_ready = 1'b0;
        case (state_q)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    buf_d   = blk_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
`ifdef DRAIN_PRELOAD_EN
                blk_ready = out_ready & out_last;
`endif
                if (out_ready) begin
                    buf_d = {buf_q[BUS_W-WORD_W-1:0], {WORD_W{1'b0}}};
                    idx_d = idx_q + 1'b1;
                    if (out_last) begin
                        cnt_d   = cnt_q + 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
`ifdef DRAIN_PRELOAD_EN
                        // Next block replaces the (now all-zero) buffer in the same cycle.
                        if (blk_valid) begin
                            buf_d   = blk_data;
                            state_d = SEND;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_subpel_block_drain.sv
// Bench for subpel_block_drain: word-queue reference model, directed steps plus randomized traffic.
module tb_subpel_block_drain;

`ifdef DRAIN_PRELOAD_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           blk_valid;
    logic           blk_ready;
    logic [2559:0]  blk_data;
    logic           out_valid;
    logic           out_ready;
    logic [63:0]    out_data;
    logic [5:0]     out_idx;
    logic           out_last;
    logic           busy;
    logic [15:0]    blk_count;

    logic           w_blk_ready, w_out_valid, w_out_last, w_busy;
    logic [63:0]    w_out_data;
    logic [5:0]     w_out_idx;
    logic [1:0]     w_blk_count;

    always #5 clk = ~clk;

    subpel_block_drain dut (
        .clock(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .blk_count(blk_count)
    );

    // Narrow block counter instance so wrap-around is reached in a short run.
    subpel_block_drain #(.BCNT_W(2)) dut_w (
        .clock(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(w_blk_ready),
        .blk_data(blk_data), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_idx(w_out_idx), .out_last(w_out_last),
        .busy(w_busy), .blk_count(w_blk_count)
    );

    logic [63:0]    q[$];
    int unsigned    exp_idx;
    logic [15:0]    exp_cnt;
    bit             chk_on;
    bit             obs_valid;
    bit             acc;
    int             n_assert = 0;
    int             n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_block(input bit rnd);
        logic [7:0]  b;
        logic [63:0] w;
        for (int k = 0; k < 40; k++) begin
            b = k[7:0];
            w = rnd ? {$urandom, $urandom} : {8{b}};
            blk_data[(39-k)*64 +: 64] = w;
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic step();
        bit rdy_exp;
        #1;
        rdy_exp   = (q.size() == 0) || (PRE && out_ready && q.size() == 1);
        obs_valid = out_valid;
        if (chk_on) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
            chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
            chk("blk_ready", {63'd0, blk_ready}, {63'd0, rdy_exp});
            chk("out_data", out_data, (q.size() != 0) ? q[0] : 64'd0);
            chk("out_last", {63'd0, out_last}, {63'd0, q.size() == 1});
            if (q.size() != 0) chk("out_idx", {58'd0, out_idx}, 64'(exp_idx));
            chk("blk_count", {48'd0, blk_count}, {48'd0, exp_cnt});
            chk("blk_count_narrow", {62'd0, w_blk_count}, {62'd0, exp_cnt[1:0]});
            chk("narrow_out_data", w_out_data, out_data);
        end
        acc = 1'b0;
        if (reset) begin
            q.delete();
            exp_idx = 0;
            exp_cnt = '0;
        end else begin
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
                exp_idx++;
                if (q.size() == 0) begin
                    exp_cnt++;
                    exp_idx = 0;
                end
            end
            if (blk_valid && rdy_exp) begin
                acc = 1'b1;
                for (int k = 0; k < 40; k++) q.push_back(blk_data[(39-k)*64 +: 64]);
                exp_idx = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int nacc, gap, ones;
        bit seen;
        reset = 1'b1; blk_valid = 1'b0; out_ready = 1'b0; blk_data = '0;
        chk_on = 1'b0; exp_idx = 0; exp_cnt = '0;
        @(negedge clk);
        step(); step();
        reset = 1'b0; chk_on = 1'b1;
        step();

        // Counting-pattern block at full rate
        set_block(1'b0); blk_valid = 1'b1; out_ready = 1'b1;
        step();
        blk_valid = 1'b0;
        repeat (41) step();
        chk("t1_blk_count", {48'd0, blk_count}, 64'd1);

        // Same block with out_ready pattern 1,0,0
        set_block(1'b0); blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int i = 0; i < 125; i++) begin
            out_ready = (i % 3 == 0);
            step();
        end
        chk("t2_drained", {63'd0, out_valid}, 64'd0);

        // Two blocks offered back to back
        set_block(1'b1); blk_valid = 1'b1; out_ready = 1'b1;
        nacc = 0; gap = 0; ones = 0; seen = 1'b0;
        for (int i = 0; i < 90; i++) begin
            step();
            if (obs_valid) begin
                seen = 1'b1;
                ones++;
            end else if (seen && ones < 80) begin
                gap++;
            end
            if (acc) begin
                nacc++;
                if (nacc == 1) set_block(1'b1);
                else blk_valid = 1'b0;
            end
        end
        chk("t3_gap", 64'(gap), PRE ? 64'd0 : 64'd1);
        chk("t3_accepts", 64'(nacc), 64'd2);
        chk("t3_valid_cycles", 64'(ones), 64'd80);

        // Reset after 18 words (0..17) accepted
        set_block(1'b1); blk_valid = 1'b1; out_ready = 1'b1;
        step();
        blk_valid = 1'b0;
        repeat (18) step();
        chk("t4_idx_at_reset", {58'd0, out_idx}, 64'd18);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("t4_valid_after_reset", {63'd0, out_valid}, 64'd0);
        chk("t4_data_after_reset", out_data, 64'd0);
        chk("t4_ready_after_reset", {63'd0, blk_ready}, 64'd1);
        chk("t4_count_after_reset", {48'd0, blk_count}, 64'd0);
        set_block(1'b0); blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        repeat (41) step();

        // Random blk_data every cycle, random valid/ready
        for (int i = 0; i < 400; i++) begin
            set_block(1'b1);
            blk_valid = ($urandom % 2) == 1;
            out_ready = ($urandom % 4) != 0;
            step();
        end
        blk_valid = 1'b0; out_ready = 1'b1;
        repeat (45) step();

        // Enough blocks to wrap the narrow counter at least once more
        for (int b = 0; b < 6; b++) begin
            set_block(1'b1); blk_valid = 1'b1;
            step();
            blk_valid = 1'b0;
            repeat (41) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
